// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GCM counter-sequencing types and constants
package gcm_pkg;
    localparam int GCM_BLK_W = 128;
    localparam int GCM_IV_W = 96;
    localparam logic [31:0] GCM_J0_CTR = 32'h1;
    localparam logic [31:0] GCM_FIRST_DATA_CTR = 32'h2;
    typedef enum logic [1:0] {IDLE, ISSUE_J0, ISSUE_DATA, DRAIN} gcm_state_e;
endpackage

// File: rtl/gcm_ctr_sequencer_if.sv
// gcm_ctr_sequencer_if: job config, AES issue/retire and status signals
interface gcm_ctr_sequencer_if #(parameter int NBLK_W = 16);
    import gcm_pkg::*;
    logic cfg_valid;
    logic cfg_ready;
    logic [GCM_IV_W-1:0] cfg_iv;
    logic [NBLK_W-1:0] cfg_nblk;
    logic aes_valid;
    logic aes_ready;
    logic [GCM_BLK_W-1:0] aes_ctr_blk;
    logic aes_is_j0;
    logic aes_last;
    logic rsp_valid;
    logic busy;
    logic done;
    logic err_unexp;
    modport master (
        output cfg_valid, cfg_iv, cfg_nblk, aes_ready, rsp_valid,
        input cfg_ready, aes_valid, aes_ctr_blk, aes_is_j0, aes_last, busy, done, err_unexp
    );
    modport slave (
        input cfg_valid, cfg_iv, cfg_nblk, aes_ready, rsp_valid,
        output cfg_ready, aes_valid, aes_ctr_blk, aes_is_j0, aes_last, busy, done, err_unexp
    );
endinterface

// File: rtl/gcm_credit_cnt.sv
// gcm_credit_cnt: saturating in-flight block counter with sticky underflow flag
module gcm_credit_cnt #(parameter int MAX_OUT = 4) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_clr_err,
    output logic [3:0] o_count,
    output logic       o_err_unexp
);
    logic [3:0] r_count;
    logic r_err;
    logic w_dec_ok;
    logic w_inc_ok;
    assign w_dec_ok = i_dec && r_count != 4'd0;
    assign w_inc_ok = i_inc && (r_count != 4'(MAX_OUT) || w_dec_ok);
    assign o_count = r_count;
    assign o_err_unexp = r_err;
    // A stray retire in the same cycle as a clear still reports the error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
            r_err <= 1'b0;
        end else begin
            r_count <= r_count + 4'(w_inc_ok) - 4'(w_dec_ok);
            if (i_dec && r_count == 4'd0) r_err <= 1'b1;
            else if (i_clr_err) r_err <= 1'b0;
        end
    end
endmodule

// File: rtl/gcm_ctr_sequencer.sv
// gcm_ctr_sequencer: issues J0 then inc32 data counter blocks to the AES core,
// throttled by the number of blocks in flight
module gcm_ctr_sequencer import gcm_pkg::*; #(
    parameter int NBLK_W = 16,
    parameter int MAX_OUT = 4
) (
    input logic clk,
    input logic rst,
    gcm_ctr_sequencer_if.slave bus
);
    gcm_state_e r_state, w_next;
    logic [GCM_IV_W-1:0] r_iv;
    logic [31:0] r_ctr;
    logic [NBLK_W-1:0] r_rem;
    logic [3:0] w_out;
    logic w_issue, w_hs, w_done, w_accept;
    gcm_credit_cnt #(.MAX_OUT(MAX_OUT)) u_credit (
        .clk(clk),
        .rst(rst),
        .i_inc(w_hs),
        .i_dec(bus.rsp_valid),
        .i_clr_err(w_accept),
        .o_count(w_out),
        .o_err_unexp(bus.err_unexp)
    );
    always_comb begin
        w_issue = (r_state == ISSUE_J0 || r_state == ISSUE_DATA) && w_out < 4'(MAX_OUT);
        w_hs = w_issue && bus.aes_ready;
        w_done = r_state == DRAIN && w_out == 4'd0;
        w_accept = bus.cfg_valid && (r_state == IDLE || w_done);
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_accept ? ISSUE_J0 : IDLE;
            ISSUE_J0: if (w_hs) w_next = r_rem == '0 ? DRAIN : ISSUE_DATA;
            ISSUE_DATA: if (w_hs && r_rem == NBLK_W'(1)) w_next = DRAIN;
            DRAIN: if (w_done) w_next = w_accept ? ISSUE_J0 : IDLE;
            default: w_next = IDLE;
        endcase
    end
    assign bus.cfg_ready = r_state == IDLE || w_done;
    assign bus.aes_valid = w_issue;
    assign bus.aes_ctr_blk = w_issue ? {r_iv, r_ctr} : '0;
    assign bus.aes_is_j0 = r_state == ISSUE_J0;
    assign bus.aes_last = (r_state == ISSUE_J0 && r_rem == '0) || (r_state == ISSUE_DATA && r_rem == NBLK_W'(1));
    assign bus.busy = r_state != IDLE;
    assign bus.done = w_done;
    // r_ctr only wraps in its own 32 bits; the IV register is never touched after accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_iv <= '0;
            r_ctr <= '0;
            r_rem <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_iv <= bus.cfg_iv;
                r_ctr <= GCM_J0_CTR;
                r_rem <= bus.cfg_nblk;
            end else if (w_hs) begin
                r_ctr <= r_state == ISSUE_J0 ? GCM_FIRST_DATA_CTR : r_ctr + 32'd1;
                if (r_state == ISSUE_DATA) r_rem <= r_rem - NBLK_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gcm_ctr_sequencer.sv
// tb_gcm_ctr_sequencer: randomized bench checked every cycle against a job-level model
module tb_gcm_ctr_sequencer;
    localparam int MAXO = 4;
    localparam logic [95:0] IV1 = 96'hCAFEBABEFACEDBADDECAF888;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    gcm_ctr_sequencer_if #(.NBLK_W(16)) bus ();
    gcm_ctr_sequencer #(.NBLK_W(16), .MAX_OUT(MAXO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    bit m_act, m_j0, m_err, m_fresh;
    int unsigned m_rem;
    logic [31:0] m_ctr;
    logic [95:0] m_iv;
    int m_out;
    int rsp_mode;
    bit rdy_rand;
    bit last_acc;
    logic [7:0] lat_pipe;
    int pend;
    int n_hs_obs, n_done_obs;
    logic [129:0] log_q[$];

    task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic ev, ed, ecr, hs, rsp;
        logic [127:0] eb;
        @(negedge clk);
        ev = m_act && (m_j0 || m_rem != 0) && m_out < MAXO;
        ed = m_act && !m_j0 && m_rem == 0 && m_out == 0;
        ecr = !m_act || ed;
        eb = {m_iv, m_j0 ? 32'h1 : m_ctr};
        check("cfg_ready", 130'(bus.cfg_ready), 130'(ecr));
        check("aes_valid", 130'(bus.aes_valid), 130'(ev));
        check("busy", 130'(bus.busy), 130'(m_act));
        check("done", 130'(bus.done), 130'(ed));
        check("err_unexp", 130'(bus.err_unexp), 130'(m_err));
        if (ev) begin
            check("ctr_blk", 130'(bus.aes_ctr_blk), 130'(eb));
            check("is_j0", 130'(bus.aes_is_j0), 130'(m_j0));
            check("last", 130'(bus.aes_last), 130'(m_j0 ? m_rem == 0 : m_rem == 1));
        end else if (m_fresh) begin
            check("rst_blk", 130'(bus.aes_ctr_blk), 130'(0));
            check("rst_j0", 130'(bus.aes_is_j0), 130'(0));
            check("rst_last", 130'(bus.aes_last), 130'(0));
        end
        if (bus.aes_valid && bus.aes_ready) begin
            n_hs_obs++;
            log_q.push_back({bus.aes_is_j0, bus.aes_last, bus.aes_ctr_blk});
        end
        if (bus.done) n_done_obs++;
        @(posedge clk);
        hs = ev && bus.aes_ready;
        rsp = bus.rsp_valid;
        last_acc = 1'b0;
        if (rst) begin
            m_act = 0; m_j0 = 0; m_rem = 0; m_out = 0; m_err = 0; m_fresh = 1;
            lat_pipe = '0; pend = 0;
        end else begin
            if (hs) begin
                if (m_j0) m_j0 = 0;
                else begin m_ctr = m_ctr + 32'd1; m_rem = m_rem - 1; end
            end
            if (ed) m_act = 0;
            if (bus.cfg_valid && ecr) begin
                m_act = 1; m_j0 = 1; m_iv = bus.cfg_iv; m_rem = bus.cfg_nblk;
                m_ctr = 32'h2; m_err = 0; m_fresh = 0; last_acc = 1;
            end
            if (rsp && m_out == 0) m_err = 1;
            m_out = m_out + int'(hs) - int'(rsp && m_out != 0);
            lat_pipe = {lat_pipe[6:0], hs};
            if (rsp_mode == 2) pend = pend + int'(hs) - int'(rsp && pend > 0);
            else pend = 0;
        end
        #1;
        if (rdy_rand) bus.aes_ready = 1'($urandom_range(0, 1));
        case (rsp_mode)
            0: bus.rsp_valid = 1'b0;
            1: bus.rsp_valid = lat_pipe[2];
            2: bus.rsp_valid = pend > 0 && $urandom_range(0, 2) == 0;
            default: ;
        endcase
    endtask

    task automatic start_job(input logic [95:0] iv, input logic [15:0] nblk);
        bit ok = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_iv = iv;
        bus.cfg_nblk = nblk;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = last_acc;
        end
        bus.cfg_valid = 1'b0;
        if (!ok) check("cfg_accept_timeout", 130'(0), 130'(1));
    endtask

    task automatic run_until_idle(input int limit);
        for (int i = 0; i < limit && m_act; i++) tick();
        if (m_act) check("idle_timeout", 130'(1), 130'(0));
    endtask

    initial begin
        int hs0, d0;
        bus.cfg_valid = 0; bus.cfg_iv = '0; bus.cfg_nblk = '0;
        bus.aes_ready = 0; bus.rsp_valid = 0;
        rsp_mode = 0; rdy_rand = 0; pend = 0; lat_pipe = '0;
        m_act = 0; m_j0 = 0; m_err = 0; m_fresh = 1; m_rem = 0; m_out = 0; m_ctr = '0; m_iv = '0;
        n_hs_obs = 0; n_done_obs = 0;
        repeat (2) tick();
        rst = 0;
        repeat (2) tick();

        // three data blocks, responses three cycles after issue
        bus.aes_ready = 1; rsp_mode = 1; log_q.delete(); d0 = n_done_obs;
        start_job(IV1, 16'd3);
        run_until_idle(100);
        check("t1_count", 130'(log_q.size()), 130'(4));
        if (log_q.size() == 4) begin
            check("t1_b0", log_q[0], {2'b10, IV1, 32'h1});
            check("t1_b1", log_q[1], {2'b00, IV1, 32'h2});
            check("t1_b2", log_q[2], {2'b00, IV1, 32'h3});
            check("t1_b3", log_q[3], {2'b01, IV1, 32'h4});
        end
        check("t1_done", 130'(n_done_obs - d0), 130'(1));

        // empty job: J0 only
        log_q.delete(); d0 = n_done_obs;
        start_job(96'h123456789ABCDEF011223344, 16'd0);
        run_until_idle(100);
        check("t2_count", 130'(log_q.size()), 130'(1));
        if (log_q.size() == 1) check("t2_b0", log_q[0], {2'b11, 96'h123456789ABCDEF011223344, 32'h1});
        check("t2_done", 130'(n_done_obs - d0), 130'(1));

        // credit limit with responses held off
        rsp_mode = 0; hs0 = n_hs_obs;
        start_job(96'hA5A5A5A5A5A5A5A5A5A5A5A5, 16'd10);
        repeat (8) tick();
        check("t3_limit", 130'(n_hs_obs - hs0), 130'(4));
        rsp_mode = 3; bus.rsp_valid = 1; tick(); bus.rsp_valid = 0;
        repeat (4) tick();
        check("t3_one_credit", 130'(n_hs_obs - hs0), 130'(5));
        bus.rsp_valid = 1; tick(); tick(); bus.rsp_valid = 0;
        repeat (4) tick();
        check("t3_simul", 130'(n_hs_obs - hs0), 130'(7));
        rsp_mode = 2; pend = m_out;
        run_until_idle(400);

        // counter wrap forced close to the boundary
        bus.aes_ready = 1; rsp_mode = 2;
        start_job(IV1, 16'hFFFF);
        repeat (3) tick();
        bus.aes_ready = 0;
        tick();
        force dut.r_ctr = 32'hFFFFFFFE;
        m_ctr = 32'hFFFFFFFE;
        tick();
        release dut.r_ctr;
        log_q.delete();
        bus.aes_ready = 1;
        for (int i = 0; i < 100 && log_q.size() < 4; i++) tick();
        check("t4_count", 130'(log_q.size() >= 4), 130'(1));
        if (log_q.size() >= 4) begin
            check("t4_w0", log_q[0], {2'b00, IV1, 32'hFFFFFFFE});
            check("t4_w1", log_q[1], {2'b00, IV1, 32'hFFFFFFFF});
            check("t4_w2", log_q[2], {2'b00, IV1, 32'h00000000});
            check("t4_w3", log_q[3], {2'b00, IV1, 32'h00000001});
        end

        // reset mid-job, then a stray response
        d0 = n_done_obs;
        rsp_mode = 3; bus.rsp_valid = 0;
        rst = 1; tick(); rst = 0;
        tick();
        check("t5_valid", 130'(bus.aes_valid), 130'(0));
        check("t5_busy", 130'(bus.busy), 130'(0));
        check("t5_ready", 130'(bus.cfg_ready), 130'(1));
        check("t5_no_done", 130'(n_done_obs - d0), 130'(0));
        bus.rsp_valid = 1; tick(); bus.rsp_valid = 0; tick();
        check("t5_err_set", 130'(bus.err_unexp), 130'(1));
        rsp_mode = 2; rdy_rand = 1;
        start_job({$urandom, $urandom, $urandom}, 16'($urandom_range(5, 20)));
        tick();
        check("t5_err_clr", 130'(bus.err_unexp), 130'(0));
        run_until_idle(600);

        // random back-to-back jobs with random stalls
        d0 = n_done_obs;
        for (int j = 0; j < 6; j++) start_job({$urandom, $urandom, $urandom}, 16'($urandom_range(0, 12)));
        run_until_idle(600);
        check("t6_dones", 130'(n_done_obs - d0), 130'(6));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
